// File: rtl/mmu_refill.sv
// Hardware page-table walker that refills one MMU entry per miss: fetch PTE, write fault reg, write entry.
// Optional memory watchdog enabled by defining MMU_REFILL_TIMEOUT_EN.

// state    | meaning
// IDLE     | waiting for miss_req, bases writable
// FETCH    | PTE read outstanding (mem_req high)
// WR_FAULT | writing fault/tag word into MMU
// WR_ENTRY | writing translation entry into MMU
// ACK      | one-cycle miss_ack with miss_ok/refill_err
module mmu_refill #(
    parameter int RV     = 16,
    parameter int PA     = RV,
    parameter int VA     = RV,
    parameter int NMMU   = 8,
    parameter int TO_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      miss_req,
    input  logic                      miss_ins,
    input  logic                      miss_sup,
    input  logic [$clog2(NMMU)-1:0]   miss_vpn,
    input  logic                      base_we,
    input  logic [1:0]                base_sel,
    input  logic [PA-1:0]             base_data,
    output logic                      mem_req,
    output logic [PA-1:0]             mem_addr,
    input  logic                      mem_ack,
    input  logic [RV-1:0]             mem_rdata,
    output logic                      reg_write,
    output logic [RV-1:0]             reg_data,
    output logic                      miss_ack,
    output logic                      miss_ok,
    output logic                      busy,
    output logic                      refill_err
);

    localparam int VW        = $clog2(NMMU);
    localparam int UNTOUCHED = VA - VW;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR_FAULT,
        WR_ENTRY,
        ACK
    } state_t;

    state_t state_q, state_d;

    logic [PA-1:0]          base_q [4];
    logic                   ins_q;
    logic                   sup_q;
    logic [VW-1:0]          vpn_q;
    logic [PA-1:0]          addr_q;
    logic [RV-1:UNTOUCHED]  ppn_q;
    logic                   w_q;

    logic                   mem_req_q;
    logic                   reg_write_q;
    logic                   miss_ack_q;
    logic                   miss_ok_q;
    logic                   err_q;
    logic [RV-1:0]          reg_data_q;

    logic                   ok_d;
    logic                   err_d;
    logic [RV-1:0]          reg_data_d;
    logic [RV-1:0]          fault_word;
    logic [RV-1:0]          entry_word;
    logic                   timeout;

    logic [RV-UNTOUCHED+1:0] unused_rdata;
    assign unused_rdata = {mem_rdata[UNTOUCHED-1:3], mem_rdata[0]};

    always_comb begin
        fault_word            = '0;
        fault_word[RV-1 -: VW] = vpn_q;
        fault_word[3]         = ins_q;
        fault_word[2]         = sup_q;
        fault_word[1]         = 1'b1;

        entry_word                   = '0;
        entry_word[RV-1:UNTOUCHED]   = ppn_q;
        entry_word[2]                = w_q;
        entry_word[1]                = 1'b1;
        entry_word[0]                = 1'b1;
    end

`ifdef MMU_REFILL_TIMEOUT_EN
    logic [7:0] wd_q;

    assign timeout    = (wd_q == 8'(TO_CYC - 1));
    assign refill_err = err_q;

    // Counter is held at zero outside FETCH, so every FETCH entry starts fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else if (state_q != FETCH) begin
            wd_q <= '0;
        end else if (!mem_ack) begin
            wd_q <= wd_q + 8'd1;
        end
    end
`else
    logic [7:0] unused_to;
    logic       unused_err;

    assign unused_to  = 8'(TO_CYC);
    assign unused_err = err_q;
    assign timeout    = 1'b0;
    assign refill_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        reg_data_d = reg_data_q;
        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A returning PTE takes priority over a watchdog expiry in the same cycle.
                if (mem_ack) begin
                    if (mem_rdata[1]) begin
                        state_d    = WR_FAULT;
                        reg_data_d = fault_word;
                    end else begin
                        state_d = ACK;
                    end
                end else if (timeout) begin
                    state_d = ACK;
                    err_d   = 1'b1;
                end
            end
            WR_FAULT: begin
                state_d    = WR_ENTRY;
                reg_data_d = entry_word;
            end
            WR_ENTRY: begin
                state_d = ACK;
                ok_d    = 1'b1;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            reg_write_q <= 1'b0;
            miss_ack_q  <= 1'b0;
            miss_ok_q   <= 1'b0;
            err_q       <= 1'b0;
            reg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= (state_d == FETCH);
            reg_write_q <= (state_d == WR_FAULT) || (state_d == WR_ENTRY);
            miss_ack_q  <= (state_d == ACK);
            miss_ok_q   <= ok_d;
            err_q       <= err_d;
            reg_data_q  <= reg_data_d;
        end
    end

    // Request context is captured from the bases as they stood before any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ins_q  <= 1'b0;
            sup_q  <= 1'b0;
            vpn_q  <= '0;
            addr_q <= '0;
            ppn_q  <= '0;
            w_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && miss_req) begin
                ins_q  <= miss_ins;
                sup_q  <= miss_sup;
                vpn_q  <= miss_vpn;
                addr_q <= base_q[{miss_sup, miss_ins}] + PA'({miss_vpn, 1'b0});
            end
            if (state_q == FETCH && mem_ack) begin
                ppn_q <= mem_rdata[RV-1:UNTOUCHED];
                w_q   <= mem_rdata[2] & ~ins_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                base_q[i] <= '0;
            end
        end else if (base_we) begin
            base_q[base_sel] <= base_data;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign reg_write = reg_write_q;
    assign reg_data  = reg_data_q;
    assign miss_ack  = miss_ack_q;
    assign miss_ok   = miss_ok_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mmu_refill.sv
// Directed bench for mmu_refill: table of refill vectors plus hand-written corner sequences.
module tb_mmu_refill;

    localparam int RV     = 16;
    localparam int TO_CYC = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_req, miss_ins, miss_sup;
    logic [2:0]  miss_vpn;
    logic        base_we;
    logic [1:0]  base_sel;
    logic [15:0] base_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        reg_write;
    logic [15:0] reg_data;
    logic        miss_ack, miss_ok, busy, refill_err;

    int n_cmp = 0;
    int n_bad = 0;

    mmu_refill #(.RV(RV), .TO_CYC(TO_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .miss_req   (miss_req),
        .miss_ins   (miss_ins),
        .miss_sup   (miss_sup),
        .miss_vpn   (miss_vpn),
        .base_we    (base_we),
        .base_sel   (base_sel),
        .base_data  (base_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .reg_write  (reg_write),
        .reg_data   (reg_data),
        .miss_ack   (miss_ack),
        .miss_ok    (miss_ok),
        .busy       (busy),
        .refill_err (refill_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ins;
        logic        sup;
        logic [2:0]  vpn;
        logic [15:0] base;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] fault;
        logic [15:0] entry;
        logic        ok;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        base_we   = 1'b1;
        base_sel  = {v.sup, v.ins};
        base_data = v.base;
        @(negedge clk);
        base_we  = 1'b0;
        miss_req = 1'b1;
        miss_ins = v.ins;
        miss_sup = v.sup;
        miss_vpn = v.vpn;
        @(negedge clk);
        chk($sformatf("v%0d fetch req/busy", idx), {30'd0, mem_req, busy}, 32'h3);
        chk($sformatf("v%0d mem_addr", idx), {16'd0, mem_addr}, {16'd0, v.addr});
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
        @(negedge clk);
        mem_ack = 1'b0;
        if (v.ok) begin
            chk($sformatf("v%0d fault wr", idx), {15'd0, reg_write, reg_data}, {15'd0, 1'b1, v.fault});
            @(negedge clk);
            chk($sformatf("v%0d entry wr", idx), {15'd0, reg_write, reg_data}, {15'd0, 1'b1, v.entry});
            @(negedge clk);
        end
        chk($sformatf("v%0d ack/ok/err/wr", idx),
            {28'd0, miss_ack, miss_ok, refill_err, reg_write}, {28'd0, 1'b1, v.ok, 1'b0, 1'b0});
        miss_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d back idle", idx), {30'd0, busy, miss_ack}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int stall_bad;
        vecs[0] = '{1'b0, 1'b0, 3'd3, 16'h4000, 16'hA006, 16'h4006, 16'h6002, 16'hA007, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 3'd7, 16'h8000, 16'h2006, 16'h800E, 16'hE00E, 16'h2003, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 3'd1, 16'h4000, 16'h0004, 16'h4002, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 3'd2, 16'hFFFE, 16'hE002, 16'h0002, 16'h4006, 16'hE003, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 3'd5, 16'h1230, 16'h6006, 16'h123A, 16'hA00A, 16'h6003, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 3'd0, 16'h0100, 16'hFFFF, 16'h0100, 16'h0002, 16'hE007, 1'b1};

        reset = 1'b1; miss_req = 1'b0; miss_ins = 1'b0; miss_sup = 1'b0; miss_vpn = '0;
        base_we = 1'b0; base_sel = '0; base_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset outputs", {26'd0, mem_req, reg_write, miss_ack, miss_ok, busy, refill_err}, 32'h0);

        // stray mem_ack in IDLE must do nothing
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        repeat (2) @(negedge clk);
        chk("stray mem_ack", {28'd0, busy, reg_write, miss_ack, mem_req}, 32'h0);
        mem_ack = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // reset mid-FETCH, then the held request is re-serviced with cleared bases
        @(negedge clk);
        miss_req = 1'b1; miss_ins = 1'b0; miss_sup = 1'b0; miss_vpn = 3'd2;
        @(negedge clk);
        chk("pre-reset fetch", {31'd0, mem_req}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset mid-fetch", {28'd0, mem_req, busy, miss_ack, reg_write}, 32'h0);
        @(negedge clk);
        chk("post-reset addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0004});
        mem_ack = 1'b1; mem_rdata = 16'h0000;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("post-reset ack", {29'd0, miss_ack, miss_ok, reg_write}, 32'h4);
        miss_req = 1'b0;

        // same-cycle base write latches old base; later writes leave mem_addr alone
        @(negedge clk);
        base_we = 1'b1; base_sel = 2'b00; base_data = 16'h3000;
        miss_req = 1'b1; miss_vpn = 3'd1;
        @(negedge clk);
        chk("old base latched", {16'd0, mem_addr}, 32'h0002);
        base_data = 16'h7000;
        @(negedge clk);
        base_we = 1'b0;
        chk("addr held", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0002});
        // requester drops miss_req early; sequence must still finish
        miss_req = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!mem_req || miss_ack || reg_write) stall_bad++;
        end
        chk("stall without ack", stall_bad, 0);
        mem_ack = 1'b1; mem_rdata = 16'hA006;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("dropped-req fault", {15'd0, reg_write, reg_data}, {15'd0, 1'b1, 16'h2002});
        @(negedge clk);
        chk("dropped-req entry", {15'd0, reg_write, reg_data}, {15'd0, 1'b1, 16'hA007});
        @(negedge clk);
        chk("dropped-req ack", {30'd0, miss_ack, miss_ok}, 32'h3);

        // back-to-back: request held through ACK is taken only after the IDLE cycle
        @(negedge clk);
        miss_req = 1'b1; miss_vpn = 3'd1;
        @(negedge clk);
        chk("new base used", {16'd0, mem_addr}, 32'h7002);
        mem_ack = 1'b1; mem_rdata = 16'h0000;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b first ack", {31'd0, miss_ack}, 32'h1);
        @(negedge clk);
        chk("b2b idle gap", {30'd0, mem_req, busy}, 32'h0);
        @(negedge clk);
        chk("b2b second fetch", {30'd0, mem_req, busy}, 32'h3);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b second ack", {31'd0, miss_ack}, 32'h1);
        miss_req = 1'b0;

`ifdef MMU_REFILL_TIMEOUT_EN
        begin
            int cnt, writes;
            @(negedge clk);
            miss_req = 1'b1; miss_vpn = 3'd4;
            cnt = 0; writes = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (reg_write) writes++;
                if (miss_ack) break;
                if (mem_req) cnt++;
            end
            chk("timeout fetch cycles", cnt, TO_CYC);
            chk("timeout ack/err/ok", {29'd0, miss_ack, refill_err, miss_ok}, 32'h6);
            chk("timeout no writes", writes, 0);
            miss_req = 1'b0;
            @(negedge clk);
        end
`endif

        @(negedge clk);
        chk("final idle", {28'd0, busy, mem_req, miss_ack, refill_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
